// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing stream decoder.
//   sc_state_e       : decoder FSM state (ACCUM collects a window, HOLD presents the result)
//   SC_WIN_LOG2_DEF  : default log2 of the window length in bits
package sc_pkg;

  localparam int unsigned SC_WIN_LOG2_DEF = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } sc_state_e;

endpackage : sc_pkg

// File: rtl/sc_window_counter.sv
// Window sample counter and ones counter for the stream decoder.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   inc_i      : one sample accepted this cycle
//   bit_i      : value of the accepted sample
//   clr_i      : discard the window (zero both counters); wins over inc_i
//   ones_o     : ones seen so far in the current window (excludes this cycle's sample)
//   last_c     : the sample counter is at N-1, so the next accepted sample closes the window
module sc_window_counter
  import sc_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = SC_WIN_LOG2_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_i,
  input  logic              bit_i,
  input  logic              clr_i,
  output logic [WIN_LOG2:0] ones_o,
  output logic              last_c
);

  localparam int unsigned CNT_W  = WIN_LOG2;
  localparam int unsigned ONES_W = WIN_LOG2 + 1;
  localparam int unsigned N      = 1 << WIN_LOG2;

  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic [ONES_W-1:0] ones_q, ones_d;

  assign last_c = (cnt_q == CNT_W'(N - 1));
  assign ones_o = ones_q;

  // Closing the window zeroes both counters explicitly so nothing carries across windows.
  always_comb begin
    cnt_d  = cnt_q;
    ones_d = ones_q;
    if (clr_i) begin
      cnt_d  = '0;
      ones_d = '0;
    end else if (inc_i) begin
      if (last_c) begin
        cnt_d  = '0;
        ones_d = '0;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
        ones_d = ones_q + ONES_W'(bit_i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      ones_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      ones_q <= ones_d;
    end
  end

endmodule : sc_window_counter

// File: rtl/sc_stream_decoder.sv
// Stochastic bitstream decoder: counts ones over a window of N = 2^WIN_LOG2 accepted
// samples and presents the count with a valid/ready handshake.
// Optional feature macro: SC_DEC_BIPOLAR_EN -- result is signed 2*ones - N, WIN_LOG2+2 bits.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (priority over clear)
//   clear      : abort the current window / drop a held result
//   in_valid   : in_bit carries a sample
//   in_bit     : stochastic bitstream sample
//   in_ready   : decoder accepts a sample this cycle
//   out_valid  : out_value holds a completed window result
//   out_value  : decoded value, 0 when out_valid is low
//   out_ready  : consumer takes out_value
//   busy       : window partially filled or result held
module sc_stream_decoder
  import sc_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = SC_WIN_LOG2_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic in_valid,
  input  logic in_bit,
  output logic in_ready,
  output logic out_valid,
`ifdef SC_DEC_BIPOLAR_EN
  output logic [WIN_LOG2+1:0] out_value,
`else
  output logic [WIN_LOG2:0]   out_value,
`endif
  input  logic out_ready,
  output logic busy
);

  localparam int unsigned ONES_W = WIN_LOG2 + 1;
`ifdef SC_DEC_BIPOLAR_EN
  localparam int unsigned OUT_W  = WIN_LOG2 + 2;
  localparam int unsigned N      = 1 << WIN_LOG2;
`else
  localparam int unsigned OUT_W  = WIN_LOG2 + 1;
`endif

  sc_state_e         state_q,  state_d;
  logic [OUT_W-1:0]  result_q, result_d;
  logic              busy_q,   busy_d;

  logic              accept_c;
  logic              last_c;
  logic [ONES_W-1:0] ones_c;
  logic [ONES_W-1:0] total_c;
  logic [OUT_W-1:0]  encoded_c;

  assign accept_c = (state_q == ACCUM) && in_valid;

  sc_window_counter #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_win_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (accept_c && !clear),
    .bit_i  (in_bit),
    .clr_i  (clear),
    .ones_o (ones_c),
    .last_c (last_c)
  );

  // Count including the sample that closes the window; never exceeds N so no overflow.
  assign total_c = ones_c + ONES_W'(in_bit);

`ifdef SC_DEC_BIPOLAR_EN
  // 2*ones - N in two's complement; {total,0} is 2*ones at full width.
  assign encoded_c = {total_c, 1'b0} - OUT_W'(N);
`else
  assign encoded_c = OUT_W'(total_c);
`endif

  // Next state: result register is zeroed whenever nothing is held, so it drives out_value directly.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    busy_d   = busy_q;
    unique case (state_q)
      ACCUM: begin
        if (accept_c) begin
          busy_d = 1'b1;
          if (last_c) begin
            state_d  = HOLD;
            result_d = encoded_c;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d  = ACCUM;
          result_d = '0;
          busy_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
    if (clear) begin
      state_d  = ACCUM;
      result_d = '0;
      busy_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ACCUM;
      result_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      busy_q   <= busy_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_value = result_q;
  assign busy      = busy_q;

endmodule : sc_stream_decoder

// File: tb/tb_sc_stream_decoder.sv
// Directed bench for sc_stream_decoder at WIN_LOG2=4 (N=16); follows SC_DEC_BIPOLAR_EN.
module tb_sc_stream_decoder;

  localparam int unsigned WL = 4;
`ifdef SC_DEC_BIPOLAR_EN
  localparam int unsigned OW = WL + 2;
`else
  localparam int unsigned OW = WL + 1;
`endif

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          in_bit;
  logic          in_ready;
  logic          out_valid;
  logic [OW-1:0] out_value;
  logic          out_ready;
  logic          busy;

  int checks;
  int errors;

  sc_stream_decoder #(
    .WIN_LOG2 (WL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_value (out_value),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Expected encoding of a window with the given ones count.
  function automatic logic [OW-1:0] enc(input int ones);
`ifdef SC_DEC_BIPOLAR_EN
    return OW'(2 * ones - 16);
`else
    return OW'(ones);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample after 'gap' idle cycles.
  task automatic send(input logic b, input int gap);
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_bit   = b;
    tick();
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic idle_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_value"}, 32'(out_value), 32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  // Check a held result, complete the handshake, check the return to idle.
  task automatic take(input string tag, input int ones);
    check({tag, "_valid"},    32'(out_valid), 32'd1);
    check({tag, "_value"},    32'(out_value), 32'(enc(ones)));
    check({tag, "_in_ready"}, 32'(in_ready),  32'd0);
    check({tag, "_busy"},     32'(busy),      32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    idle_outputs({tag, "_post"});
  endtask

  initial begin
    logic [15:0] pat;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    idle_outputs("reset");

    // 16 ones back to back; no result until the 16th is accepted.
    for (int i = 0; i < 15; i++) send(1'b1, 0);
    check("ones15_valid", 32'(out_valid), 32'd0);
    check("ones15_busy",  32'(busy),      32'd1);
    send(1'b1, 0);
    take("all_ones", 16);

    // 16 zeros with gaps.
    for (int i = 0; i < 16; i++) begin
      send(1'b0, i % 4);
      if (i == 7) check("zeros_busy_mid", 32'(busy), 32'd1);
    end
    take("all_zeros", 0);

    // Alternating 1,0.
    for (int i = 0; i < 16; i++) send(logic'(i % 2 == 0), 0);
    take("alternate", 8);

    // Output stall: 5 ones then 11 zeros, ones offered during the stall must be ignored.
    for (int i = 0; i < 16; i++) send(logic'(i < 5), 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'b1;
      tick();
      check("stall_valid",    32'(out_valid), 32'd1);
      check("stall_value",    32'(out_value), 32'(enc(5)));
      check("stall_in_ready", 32'(in_ready),  32'd0);
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
    take("stall", 5);
    pat = 16'b0000_0100_1000_0001;
    for (int i = 0; i < 16; i++) send(pat[i], 0);
    take("after_stall", 3);

    // Clear mid-window, with a sample presented in the clearing cycle.
    for (int i = 0; i < 7; i++) send(1'b1, 0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    idle_outputs("clear_mid");
    for (int i = 0; i < 16; i++) send(1'b0, 0);
    take("clear_then_zeros", 0);

    // Clear while holding a result drops it without a handshake.
    for (int i = 0; i < 16; i++) send(1'b1, 0);
    check("clear_hold_valid", 32'(out_valid), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    idle_outputs("clear_hold");

    // Reset mid-window with a sample offered, also with clear asserted.
    for (int i = 0; i < 5; i++) send(1'b1, 0);
    rst_n    = 1'b0;
    clear    = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    tick();
    rst_n    = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    idle_outputs("reset_mid");
    for (int i = 0; i < 16; i++) send(logic'(i < 10), i % 2);
    take("after_reset", 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sc_stream_decoder

// File: doc/sc_stream_decoder.md
SC_STREAM_DECODER -- requirements
Module: sc_stream_decoder

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 8, giving log2 of the window length in bits (N = 2^WIN_LOG2), legal range 2..16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port clear, input, 1 bit: synchronous abort that discards the current window.
REQ-005 SHALL have port in_valid, input, 1 bit: in_bit is valid this cycle.
REQ-006 SHALL have port in_bit, input, 1 bit: one stochastic bitstream sample.
REQ-007 SHALL have port in_ready, output, 1 bit: decoder accepts a sample this cycle.
REQ-008 SHALL have port out_valid, output, 1 bit: out_value holds a completed window result.
REQ-009 SHALL have port out_value, output, WIN_LOG2+1 bits (WIN_LOG2+2 with SC_DEC_BIPOLAR_EN): decoded value.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts out_value.
REQ-011 SHALL have port busy, output, 1 bit: high when at least one sample of the current window has been accepted, or when a result is held.

Function
REQ-012 SHALL implement a two-state FSM: ACCUM and HOLD.
REQ-013 ACCUM SHALL drive in_ready=1 and out_valid=0; a sample is accepted when in_valid&&in_ready.
REQ-014 Each accepted sample SHALL increment the sample counter (WIN_LOG2 bits) and add in_bit to the ones counter (WIN_LOG2+1 bits).
REQ-015 Cycles with in_valid=0 SHALL leave both counters unchanged; gaps are unlimited.
REQ-016 When the Nth sample is accepted (sample counter == N-1), the FSM SHALL go to HOLD, latch ones+in_bit into the result register and clear both counters in the same edge.
REQ-017 Latency: out_valid SHALL assert on the cycle immediately after the edge that accepted the Nth sample.
REQ-018 HOLD SHALL drive in_ready=0 and out_valid=1, with out_value stable until the handshake completes.
REQ-019 In HOLD, out_valid&&out_ready SHALL return the FSM to ACCUM on that edge; in_ready is 1 the following cycle (no same-cycle accept; one idle input slot per window).
REQ-020 Result range, unipolar: 0..N inclusive (all-ones window = N, which requires the extra MSB).
REQ-021 Counters SHALL never wrap within a window; the sample counter reaching N-1 always causes the transition.
REQ-022 clear=1 SHALL, on that edge, zero both counters and the result register and force ACCUM; clear has priority over in_valid and out_ready; a sample presented in the same cycle is discarded.
REQ-023 out_value SHALL read 0 whenever out_valid=0.

Reset
REQ-024 rst_n=0 at a rising edge SHALL force ACCUM, zero both counters and the result register; outputs after reset: in_ready=1, out_valid=0, out_value=0, busy=0.
REQ-025 Reset mid-window or in HOLD SHALL discard all partial and held results with no output handshake.
REQ-026 Reset SHALL have priority over clear.

Configuration
REQ-027 Macro SC_DEC_BIPOLAR_EN defined: out_value SHALL be signed two's complement of width WIN_LOG2+2, equal to 2*ones - N (range -N..+N).
REQ-028 Macro SC_DEC_BIPOLAR_EN undefined: out_value SHALL be unsigned ones count of width WIN_LOG2+1; no bipolar logic is present.

Structure
REQ-029 Package sc_pkg SHALL hold the FSM state enum (ACCUM, HOLD) and the default WIN_LOG2 constant.
REQ-030 The sample counter and ones counter SHALL live in one sub-module, sc_window_counter (inputs: inc, bit, clr; outputs: ones, last).

Verification (WIN_LOG2=4, N=16)
REQ-031 16 accepted ones back-to-back -> out_valid the cycle after the 16th, out_value=16 (bipolar: +16).
REQ-032 16 zeros with random in_valid gaps -> out_value=0 (bipolar: -16); no samples lost or double-counted.
REQ-033 Alternating 1,0 for 16 samples -> out_value=8 (bipolar: 0).
REQ-034 out_ready held low 5 cycles after result -> out_valid and out_value stable, in_ready=0, samples offered during the stall are not counted; after the handshake the next window counts only new samples.
REQ-035 clear pulsed after 7 ones, then 16 zeros -> out_value=0; clear in HOLD -> out_valid drops next cycle with no handshake.
REQ-036 rst_n low for one cycle mid-window with in_valid=1 -> all outputs at reset values next cycle; the next full window decodes correctly.
